instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle RISC-V datapath. Holds the program counter, stores program words in a loadable 32-bit instruction memory, and presents one instruction per cycle, with its PC, to the decode stage over a valid/ready handshake. It replaces the free-running bench counter as the address source, and it supports redirects for branches and jumps.

---
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, loadable imem, valid/ready output to decode
// Optional feature macro: IFETCH_MISALIGN_EN (sticky fault and fetch halt on misaligned redirect)
module instr_fetch #(
  parameter int          ADDR_WIDTH = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  imem_we,
  input  logic [ADDR_WIDTH-1:0] imem_waddr,
  input  logic [31:0]           imem_wdata,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  output logic                  fault
);

  localparam int PC_W = ADDR_WIDTH + 2;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [PC_W-1:0]       pc;
  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic [31:0]           fetch_word;
  logic [PC_W-1:0]       redirect_target;
  logic                  misaligned;
  logic                  halted;
  logic                  advance;
  logic                  unused_redirect_bits;

  assign fetch_idx            = pc[PC_W-1:2];
  assign fetch_word           = mem[fetch_idx];
  assign redirect_target      = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_redirect_bits = ^{redirect_pc[31:PC_W], redirect_pc[1:0]};

`ifdef IFETCH_MISALIGN_EN
  logic fault_q;

  assign misaligned = (redirect_pc[1:0] != 2'b00);
  assign halted     = fault_q;
  assign fault      = fault_q;

  // Sticky until reset; while set, fetch never advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && misaligned) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misaligned = 1'b0;
  assign halted     = 1'b0;
  assign fault      = 1'b0;
`endif

  assign advance = (!out_valid || out_ready) && !redirect_valid && !halted;

  // Program load port; no reset so contents survive a reset of the fetch state.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC[PC_W-1:0];
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
    end else if (redirect_valid) begin
      // Flush whatever is presented, stalled or not.
      out_valid <= 1'b0;
      if (!misaligned) begin
        pc <= redirect_target;
      end
    end else if (advance) begin
      out_instr <= fetch_word;
      out_pc    <= 32'(pc);
      out_valid <= 1'b1;
      pc        <= pc + PC_W'(4);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a transfer-level reference model
module tb_instr_fetch;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          fault;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_mem [DEPTH];

  instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1; imem_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      case (i)
        0: w = 32'h01c38333;
        1: w = 32'h41c38333;
        2: w = 32'h01c3c333;
        3: w = 32'h00000013;
        default: w = $urandom;
      endcase
      if (w == 32'hDEADBEEF) w = 32'h0;
      imem_we = 1'b1; imem_waddr = AW'(i); imem_wdata = w;
      tick();
      model_mem[i] = w;
    end
    imem_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", fault); end
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b expected 1", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL first_pc: got %h expected 0", out_pc); end
    vectors++; if (out_instr !== model_mem[0]) begin miscompares++; $display("FAIL first_instr: got %h expected %h", out_instr, model_mem[0]); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k < 4; k++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL seq_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", k, out_valid, out_pc, 32'(4 * k)); end
      vectors++; if (out_instr !== model_mem[k]) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, out_instr, model_mem[k]); end
    end
  endtask

  task automatic test_wrap();
    repeat (60) tick();
    vectors++; if (out_pc !== 32'hFC) begin miscompares++; $display("FAIL wrap_last_pc: got %h expected 000000fc", out_pc); end
    vectors++; if (out_instr !== model_mem[63]) begin miscompares++; $display("FAIL wrap_last_instr: got %h expected %h", out_instr, model_mem[63]); end
    tick();
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h expected 0", out_pc); end
    vectors++; if (out_instr !== model_mem[0]) begin miscompares++; $display("FAIL wrap_instr: got %h expected %h", out_instr, model_mem[0]); end
  endtask

  task automatic test_backpressure();
    restart();
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d]: got v=%b pc=%h expected v=1 pc=8", i, out_valid, out_pc); end
      vectors++; if (out_instr !== model_mem[2]) begin miscompares++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, out_instr, model_mem[2]); end
    end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_pc !== 32'hC) begin miscompares++; $display("FAIL release_pc: got %h expected c", out_pc); end
    vectors++; if (out_instr !== model_mem[3]) begin miscompares++; $display("FAIL release_instr: got %h expected %h", out_instr, model_mem[3]); end
  endtask

  task automatic test_redirect_stall();
    restart();
    repeat (2) tick();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got %b expected 0", out_valid); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin miscompares++; $display("FAIL redir_pc: got v=%b pc=%h expected v=1 pc=20", out_valid, out_pc); end
    vectors++; if (out_instr !== model_mem[8]) begin miscompares++; $display("FAIL redir_instr: got %h expected %h", out_instr, model_mem[8]); end
    out_ready = 1'b1;
  endtask

  task automatic test_misalign();
    restart();
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_EN
    for (int i = 0; i < 4; i++) begin
      vectors++; if (fault !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL misalign_halt[%0d]: got fault=%b v=%b expected fault=1 v=0", i, fault, out_valid); end
      tick();
    end
    reset = 1'b1;
    tick();
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL misalign_reset_fault: got %b expected 0", fault); end
    reset = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin miscompares++; $display("FAIL misalign_resume: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc); end
`else
    vectors++; if (out_valid !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL misalign_flush: got v=%b fault=%b expected v=0 fault=0", out_valid, fault); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin miscompares++; $display("FAIL misalign_pc: got v=%b pc=%h expected v=1 pc=20", out_valid, out_pc); end
    vectors++; if (out_instr !== model_mem[8] || fault !== 1'b0) begin miscompares++; $display("FAIL misalign_instr: got %h fault=%b expected %h fault=0", out_instr, fault, model_mem[8]); end
`endif
  endtask

  task automatic test_write_during_read();
    logic [31:0] old_word;
    restart();
    repeat (5) tick();
    old_word = model_mem[5];
    imem_we = 1'b1; imem_waddr = AW'(5); imem_wdata = 32'hDEADBEEF;
    tick();
    imem_we = 1'b0;
    model_mem[5] = 32'hDEADBEEF;
    vectors++; if (out_pc !== 32'h14 || out_instr !== old_word) begin miscompares++; $display("FAIL rbw_old: got pc=%h instr=%h expected pc=14 instr=%h", out_pc, out_instr, old_word); end
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++; if (out_pc !== 32'h14 || out_instr !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rbw_new: got pc=%h instr=%h expected pc=14 instr=deadbeef", out_pc, out_instr); end
    repeat (5) tick();
    vectors++; if (out_pc !== 32'h28) begin miscompares++; $display("FAIL midrun_pc: got %h expected 28", out_pc); end
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrun_reset_valid: got %b expected 0", out_valid); end
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== model_mem[0]) begin miscompares++; $display("FAIL midrun_restart: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=%h", out_valid, out_pc, out_instr, model_mem[0]); end
    tick();
    vectors++; if (out_pc !== 32'h4 || out_instr !== model_mem[1]) begin miscompares++; $display("FAIL midrun_next: got pc=%h instr=%h expected pc=4 instr=%h", out_pc, out_instr, model_mem[1]); end
  endtask

  // Reference: one presented slot plus the address of the next word to fetch.
  task automatic test_random();
    int          next_addr;
    logic        m_valid;
    int          m_pc;
    logic [31:0] m_instr;
    logic [31:0] fetched;
    logic        rdy, redir, wr;
    logic [31:0] tgt, wdat;
    int          widx;
    restart();
    next_addr = 0; m_valid = 1'b0; m_pc = 0; m_instr = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 9) == 0);
      wr    = ($urandom_range(0, 4) == 0);
      tgt   = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, DEPTH - 1) * 4);
      widx  = $urandom_range(0, DEPTH - 1);
      wdat  = $urandom;
      out_ready = rdy; redirect_valid = redir; redirect_pc = tgt;
      imem_we = wr; imem_waddr = AW'(widx); imem_wdata = wdat;
      fetched = model_mem[next_addr / 4];
      tick();
      if (redir) begin
        m_valid   = 1'b0;
        next_addr = int'(tgt % 256);
      end else if (!m_valid || rdy) begin
        m_valid   = 1'b1;
        m_pc      = next_addr;
        m_instr   = fetched;
        next_addr = (next_addr + 4) % 256;
      end
      if (wr) model_mem[widx] = wdat;
      vectors++; if (out_valid !== m_valid || fault !== 1'b0) begin miscompares++; $display("FAIL rand_valid[%0d]: got v=%b fault=%b expected v=%b fault=0", cyc, out_valid, fault, m_valid); end
      if (m_valid) begin
        vectors++; if (out_pc !== 32'(m_pc) || out_instr !== m_instr) begin miscompares++; $display("FAIL rand_data[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", cyc, out_pc, out_instr, 32'(m_pc), m_instr); end
      end
    end
    imem_we = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    load_program();
    test_reset();
    test_sequential();
    test_wrap();
    test_backpressure();
    test_redirect_stall();
    test_misalign();
    test_write_during_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
